// File: rtl/alu_exec_unit.sv
// RV32 execute-stage ALU with valid/ready handshakes; mul/div/rem run iteratively over 32 cycles.
// Define FAST_MUL_EN to build a single-cycle combinational multiplier (no MUL state, no shift-add datapath).
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] short_op(input logic [3:0]      code,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [4:0]             shamt;
        sa    = $signed(a);
        sb    = $signed(b);
        shamt = b[4:0];
        case (code)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SLL:  return a << shamt;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> shamt;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            OP_SRA:  return $unsigned(sa >>> shamt);
`ifdef FAST_MUL_EN
            OP_MUL:  return a * b;
`endif
            default: return '0;
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  zero_q, zero_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]       dq_q, dq_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       dvsr_q, dvsr_d;
    logic                  is_rem_q, is_rem_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;

`ifdef FAST_MUL_EN
    // Multiplication is folded into short_op; no iterative multiplier state exists.
`else
    logic [XLEN-1:0]       mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic [XLEN-1:0]       acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`endif

    logic            accept;
    logic            last_iter;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign last_iter = (cnt_q == ITER_CNT_W'(XLEN - 1));
    // Restoring step: shift in the next dividend bit, trial-subtract the divisor.
    assign div_shift = {rem_q, dq_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvsr_q};

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
`ifndef FAST_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = '0;
            case (alu_control)
`ifndef FAST_MUL_EN
                OP_MUL: begin
                    mcand_d  = operand_a;
                    mplier_d = operand_b;
                    acc_d    = '0;
                    state_d  = S_MUL;
                end
`endif
                OP_DIV, OP_REM: begin
                    is_rem_d = (alu_control == OP_REM);
                    if (operand_b == '0) begin
                        result_d = is_rem_d ? operand_a : '1;
                        state_d  = S_DONE;
                    end else if ((operand_a == INT_MIN) && (operand_b == '1)) begin
                        result_d = is_rem_d ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        dq_d    = operand_a[XLEN-1] ? negate(operand_a) : operand_a;
                        dvsr_d  = operand_b[XLEN-1] ? negate(operand_b) : operand_b;
                        rem_d   = '0;
                        q_neg_d = operand_a[XLEN-1] ^ operand_b[XLEN-1];
                        r_neg_d = operand_a[XLEN-1];
                        state_d = S_DIV;
                    end
                end
                default: begin
                    result_d = short_op(alu_control, operand_a, operand_b);
                    state_d  = S_DONE;
                end
            endcase
        end else begin
            case (state_q)
`ifndef FAST_MUL_EN
                S_MUL: begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_iter) begin
                        result_d = acc_d;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
`endif
                S_DIV: begin
                    if (!div_diff[XLEN]) begin
                        rem_d = div_diff[XLEN-1:0];
                        dq_d  = {dq_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[XLEN-1:0];
                        dq_d  = {dq_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        // Quotient sign follows operand sign mismatch; remainder follows the dividend.
                        if (is_rem_q) result_d = r_neg_q ? negate(rem_d) : rem_d;
                        else          result_d = q_neg_q ? negate(dq_d) : dq_d;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues expected results, a negedge monitor checks them.
module tb_alu_exec_unit;

    localparam logic [3:0] A_AND  = 4'b0000;
    localparam logic [3:0] A_OR   = 4'b0001;
    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SRL  = 4'b0101;
    localparam logic [3:0] A_SUB  = 4'b0110;
    localparam logic [3:0] A_SLT  = 4'b0111;
    localparam logic [3:0] A_NOP  = 4'b1000;
    localparam logic [3:0] A_SLTU = 4'b1001;
    localparam logic [3:0] A_SRA  = 4'b1010;
    localparam logic [3:0] A_MUL  = 4'b1011;
    localparam logic [3:0] A_DIV  = 4'b1100;
    localparam logic [3:0] A_REM  = 4'b1101;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    alu_exec_unit #(.XLEN(32), .ITER_CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", result, mon_exp);
                chk("zero_flag", {31'b0, zero}, {31'b0, (mon_exp == 32'd0)});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge where out_valid appears.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat);
        int n;
        int busy_hi;
        exp_q.push_back(expv);
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(negedge clk);
        chk("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        n       = 0;
        busy_hi = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_hi++;
            @(posedge clk); #1;
            n++;
        end
        chk("edges_after_accept", 32'(n), 32'(lat));
        if (lat > 0) chk("in_ready_high_while_busy", 32'(busy_hi), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        alu_control = 4'd0;
        operand_a   = 32'd0;
        operand_b   = 32'd0;
        out_ready   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_result",    result,             32'd0);
        chk("reset_zero",      {31'b0, zero},      32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(A_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
        issue(A_SUB,  32'd5,         32'd5,         32'h0000_0000, 0);
        issue(A_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
        issue(A_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0);
        issue(A_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
        issue(A_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
        issue(A_NOP,  32'd5,         32'd3,         32'h0000_0000, 0);
        issue(A_MUL,  32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, MUL_LAT);
        issue(A_MUL,  32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, MUL_LAT);
        issue(A_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
        issue(A_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
        issue(A_DIV,  32'd100,       32'd7,         32'h0000_000E, DIV_LAT);
        issue(A_REM,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT);
        issue(A_DIV,  32'd9,         32'd0,         32'hFFFF_FFFF, 0);
        issue(A_REM,  32'd9,         32'd0,         32'h0000_0009, 0);
        issue(A_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        issue(A_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        @(posedge clk); #1;

        // Result backpressure followed by a same-cycle back-to-back accept.
        out_ready = 1'b0;
        issue(A_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_result_stable", result, 32'h0F00_0F00);
            chk("bp_out_valid",     {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready",      {31'b0, in_ready},  32'd0);
        end
        exp_q.push_back(32'h0000_FF00);
        alu_control = A_XOR;
        operand_a   = 32'h0000_F0F0;
        operand_b   = 32'h0000_0FF0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("idle_after_drain", {31'b0, out_valid}, 32'd0);

        // Flush during an iterative divide.
        alu_control = A_DIV;
        operand_a   = 32'd100;
        operand_b   = 32'd7;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("div_busy_in_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'b0, in_ready},  32'd1);
        chk("flush_keeps_result", result, 32'h0000_FF00);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_out_valid", 32'(seen), 32'd0);

        // Asynchronous reset during an iterative divide.
        @(posedge clk); #1;
        alu_control = A_DIV;
        operand_a   = 32'd100;
        operand_b   = 32'd7;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("arst_result",    result,             32'd0);
        chk("arst_zero",      {31'b0, zero},      32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("arst_no_out_valid", 32'(seen), 32'd0);

        @(posedge clk); #1;
        issue(A_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
